// File: rtl/multi_in_reduce_pkg.sv
// Shared encodings for the multi-input reduction unit: reduction modes and FSM states.
package multi_in_reduce_pkg;

   localparam logic [1:0] MODE_AND = 2'b00;
   localparam logic [1:0] MODE_OR  = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_MAJ = 2'b11;

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

endpackage

// File: rtl/reduce_core.sv
// Combinational per-sample reduction of N_IN bits to one bit (AND / OR / XOR / majority).
module reduce_core
   import multi_in_reduce_pkg::*;
#(
   parameter int N_IN = 3
) (
   input  logic [N_IN-1:0] in_data,
   input  logic [1:0]      mode,
   output logic            r
);

   localparam int PW = $clog2(N_IN + 1);
   // Majority is strictly more than half, so even-width ties resolve to 0.
   localparam logic [PW-1:0] HALF = PW'(N_IN / 2);

   logic [PW-1:0] w_pop;

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < N_IN; i++) begin
         w_pop = w_pop + PW'(in_data[i]);
      end
   end

   always_comb begin
      r = 1'b0;
      case (mode)
         MODE_AND: r = &in_data;
         MODE_OR:  r = |in_data;
         MODE_XOR: r = ^in_data;
         MODE_MAJ: r = (w_pop > HALF);
         default:  r = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_in_reduce.sv
// Windowed N-input reduction: per-sample reduce, accumulate over win_len samples,
// present all/any/count summary through a valid/ready output.
module multi_in_reduce
   import multi_in_reduce_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int WIN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   input  logic [1:0]       mode,
   input  logic [WIN_W-1:0] win_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_all,
   output logic             out_any,
   output logic [WIN_W-1:0] out_cnt
);

   localparam logic [WIN_W-1:0] ONE = {{(WIN_W-1){1'b0}}, 1'b1};

   state_t           r_state, w_state_n;
   logic [1:0]       r_mode;
   logic [WIN_W-1:0] r_len;
   logic [WIN_W-1:0] r_smp_cnt;
   logic             r_acc_all, r_acc_any;
   logic [WIN_W-1:0] r_acc_cnt;
   logic             r_out_all, r_out_any;
   logic [WIN_W-1:0] r_out_cnt;

   logic             w_first, w_accept, w_last, w_r, w_hshake;
   logic [1:0]       w_mode;
   logic [WIN_W-1:0] w_len_raw, w_len, w_smp_n, w_acc_cnt_n;
   logic             w_acc_all_n, w_acc_any_n;

   // The first sample of a window uses the live mode/length; later ones use the latched copies.
   assign w_first   = (r_smp_cnt == '0);
   assign w_mode    = w_first ? mode : r_mode;
   assign w_len_raw = w_first ? win_len : r_len;
   assign w_len     = (w_len_raw == '0) ? ONE : w_len_raw;

   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_OUT);
   assign w_accept  = in_valid && in_ready;
   assign w_hshake  = out_valid && out_ready;

   reduce_core #(.N_IN(N_IN)) u_core (
      .in_data (in_data),
      .mode    (w_mode),
      .r       (w_r)
   );

   assign w_acc_all_n = (w_first ? 1'b1 : r_acc_all) & w_r;
   assign w_acc_any_n = (w_first ? 1'b0 : r_acc_any) | w_r;
   assign w_acc_cnt_n = (w_first ? '0 : r_acc_cnt) + {{(WIN_W-1){1'b0}}, w_r};
   assign w_smp_n     = r_smp_cnt + ONE;
   assign w_last      = w_accept && (w_smp_n == w_len);

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         ST_ACC:  if (w_last)   w_state_n = ST_OUT;
         ST_OUT:  if (w_hshake) w_state_n = ST_ACC;
         default: w_state_n = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_ACC;
         r_mode    <= '0;
         r_len     <= '0;
         r_smp_cnt <= '0;
         r_acc_all <= 1'b0;
         r_acc_any <= 1'b0;
         r_acc_cnt <= '0;
         r_out_all <= 1'b0;
         r_out_any <= 1'b0;
         r_out_cnt <= '0;
      end else begin
         r_state <= w_state_n;
         if (w_accept) begin
            if (w_first) begin
               r_mode <= mode;
               r_len  <= w_len;
            end
            r_acc_all <= w_acc_all_n;
            r_acc_any <= w_acc_any_n;
            r_acc_cnt <= w_acc_cnt_n;
            r_smp_cnt <= w_smp_n;
         end
         if (w_last) begin
            r_out_all <= w_acc_all_n;
            r_out_any <= w_acc_any_n;
            r_out_cnt <= w_acc_cnt_n;
         end
         if (w_hshake) begin
            r_acc_all <= 1'b0;
            r_acc_any <= 1'b0;
            r_acc_cnt <= '0;
            r_smp_cnt <= '0;
         end
      end
   end

   assign out_all = r_out_all;
   assign out_any = r_out_any;
   assign out_cnt = r_out_cnt;

endmodule

// File: tb/tb_multi_in_reduce.sv
// Directed bench for multi_in_reduce (N_IN=3, WIN_W=4): window table plus corner sequences.
module tb_multi_in_reduce;

   localparam int N_IN  = 3;
   localparam int WIN_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N_IN-1:0]  in_data;
   logic [1:0]       mode;
   logic [WIN_W-1:0] win_len;
   logic             out_valid;
   logic             out_ready;
   logic             out_all;
   logic             out_any;
   logic [WIN_W-1:0] out_cnt;

   int checks   = 0;
   int failures = 0;

   multi_in_reduce #(.N_IN(N_IN), .WIN_W(WIN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mode      (mode),
      .win_len   (win_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_all   (out_all),
      .out_any   (out_any),
      .out_cnt   (out_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [1:0] md;
      logic [3:0] len;
      int         n;
      logic [44:0] smp;   // sample i occupies bits [3i+2:3i]
      int         e_all;
      int         e_any;
      int         e_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_out(input string nm, input int a, input int y, input int c);
      chk({nm, ".out_valid"}, int'(out_valid), 1);
      chk({nm, ".in_ready"},  int'(in_ready), 0);
      chk({nm, ".out_all"},   int'(out_all), a);
      chk({nm, ".out_any"},   int'(out_any), y);
      chk({nm, ".out_cnt"},   int'(out_cnt), c);
   endtask

   // Drives n back-to-back samples, then checks the summary the cycle after the last accept.
   task automatic apply(input string nm, input logic [1:0] md, input logic [3:0] len,
                        input int n, input logic [44:0] smp,
                        input int a, input int y, input int c);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({nm, ".in_ready_pre"},  int'(in_ready), 1);
         chk({nm, ".out_valid_pre"}, int'(out_valid), 0);
         in_valid = 1'b1;
         in_data  = smp[3*i +: 3];
         mode     = md;
         win_len  = len;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check_out(nm, a, y, c);
   endtask

   task automatic handshake(input string nm);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({nm, ".hs_out_valid"}, int'(out_valid), 0);
      chk({nm, ".hs_in_ready"},  int'(in_ready), 1);
   endtask

   initial begin
      vecs[0] = '{"and1_111",  2'b00, 4'd1,  1,  45'b111,                1, 1, 1};
      vecs[1] = '{"and1_110",  2'b00, 4'd1,  1,  45'b110,                0, 0, 0};
      vecs[2] = '{"or4",       2'b01, 4'd4,  4,  45'b100_000_001_000,    0, 1, 2};
      vecs[3] = '{"xor3",      2'b10, 4'd3,  3,  45'b101_110_111,        0, 1, 1};
      vecs[4] = '{"maj3",      2'b11, 4'd3,  3,  45'b001_011_110,        0, 1, 2};
      vecs[5] = '{"or_len0",   2'b01, 4'd0,  1,  45'b010,                1, 1, 1};
      vecs[6] = '{"and15",     2'b00, 4'd15, 15, {45{1'b1}},             1, 1, 15};
      vecs[7] = '{"maj2",      2'b11, 4'd2,  2,  45'b100_111,            0, 1, 1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; win_len = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.out_valid", int'(out_valid), 0);
      chk("rst.in_ready",  int'(in_ready), 1);
      chk("rst.out_all",   int'(out_all), 0);
      chk("rst.out_any",   int'(out_any), 0);
      chk("rst.out_cnt",   int'(out_cnt), 0);
      rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         apply(vecs[v].name, vecs[v].md, vecs[v].len, vecs[v].n, vecs[v].smp,
               vecs[v].e_all, vecs[v].e_any, vecs[v].e_cnt);
         handshake(vecs[v].name);
      end

      // Mode and length changed after the first sample must not affect this window.
      @(negedge clk);
      in_valid = 1'b1; in_data = 3'b111; mode = 2'b00; win_len = 4'd3;
      @(negedge clk);
      in_data = 3'b011; mode = 2'b01; win_len = 4'd1;
      @(negedge clk);
      chk("latch.no_early_valid", int'(out_valid), 0);
      in_data = 3'b101;
      @(negedge clk);
      in_valid = 1'b0;
      check_out("latch", 0, 1, 1);
      handshake("latch");

      // Backpressure: summary held, inputs ignored.
      apply("bp", 2'b00, 4'd1, 1, 45'b111, 1, 1, 1);
      in_valid = 1'b1; in_data = 3'b000; mode = 2'b01;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_out("bp_hold", 1, 1, 1);
      end
      in_valid = 1'b0;
      handshake("bp");
      chk("bp.hold_cnt_after_hs", int'(out_cnt), 1);
      chk("bp.hold_all_after_hs", int'(out_all), 1);
      apply("bp_next", 2'b00, 4'd2, 2, 45'b111_111, 1, 1, 2);
      handshake("bp_next");

      // Reset mid-window discards the partial window.
      @(negedge clk);
      in_valid = 1'b1; in_data = 3'b111; mode = 2'b00; win_len = 4'd4;
      repeat (2) @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rstmid.out_valid", int'(out_valid), 0);
      chk("rstmid.in_ready",  int'(in_ready), 1);
      chk("rstmid.out_all",   int'(out_all), 0);
      chk("rstmid.out_any",   int'(out_any), 0);
      chk("rstmid.out_cnt",   int'(out_cnt), 0);
      apply("rstmid_or4", 2'b01, 4'd4, 4, 45'b0, 0, 0, 0);
      handshake("rstmid_or4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
